// File: rtl/branch_pc_ctrl.sv
// Fetch-PC controller: sequential fetch, branch/jump/exception redirects,
// and a one-deep pending redirect that waits while the pipeline is stalled.
module branch_pc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_pc,
    input  logic [25:0] jmp_index,
    input  logic        exc,
    output logic [31:0] pc,
    output logic        flush,
    output logic        pending
);

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pend_target;

    logic        br_req;
    logic        req_any;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] sel_target;

    // Branch/jump targets; the shifted offset drops its top two bits, so the
    // add wraps modulo 2^32 exactly like a signed word offset would.
    assign br_target  = br_pc + {br_imm[29:0], 2'b00};
    assign jmp_target = {jmp_pc[31:28], jmp_index, 2'b00};
    assign br_req     = br_valid & br_taken;
    assign req_any    = exc | br_req | jmp_valid;

    // Priority select of the redirect target: exception, then branch, then jump.
    always_comb begin
        // NOTE: default first so every path assigns sel_target and no latch is inferred.
        sel_target = jmp_target;
        if (exc) begin
            sel_target = EXC_VECTOR;
        end else if (br_req) begin
            sel_target = br_target;
        end
    end

    assign pending = (state == HOLD);

    // PC, flush pulse, state and pending target update once per rising edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            pc          <= 32'h0000_0000;
            flush       <= 1'b0;
            state       <= RUN;
            pend_target <= 32'h0000_0000;
        end else begin
            unique case (state)
                RUN: begin
                    if (!stall) begin
                        if (req_any) begin
                            pc    <= sel_target;
                            flush <= 1'b1;
                        end else begin
                            pc    <= pc + 32'd4;
                            flush <= 1'b0;
                        end
                    end else begin
                        flush <= 1'b0;
                        if (req_any) begin
                            pend_target <= sel_target;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (stall) begin
                        flush <= 1'b0;
                        // Only an exception may replace a waiting redirect.
                        if (exc) begin
                            pend_target <= EXC_VECTOR;
                        end
                    end else begin
                        pc    <= exc ? EXC_VECTOR : pend_target;
                        flush <= 1'b1;
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed self-checking bench for branch_pc_ctrl.
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        jmp_valid;
    logic [31:0] jmp_pc;
    logic [25:0] jmp_index;
    logic        exc;
    logic [31:0] pc;
    logic        flush;
    logic        pending;

    int errors = 0;
    int checks = 0;

    branch_pc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .br_imm    (br_imm),
        .jmp_valid (jmp_valid),
        .jmp_pc    (jmp_pc),
        .jmp_index (jmp_index),
        .exc       (exc),
        .pc        (pc),
        .flush     (flush),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_pc     = 32'h0;
        br_imm    = 32'h0;
        jmp_valid = 1'b0;
        jmp_pc    = 32'h0;
        jmp_index = 26'h0;
        exc       = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_pc,
                             input logic exp_flush, input logic exp_pending);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, exp_flush});
        check({tag, ".pending"}, {31'b0, pending}, {31'b0, exp_pending});
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] held_pc;

        rst_n = 1'b0;
        stall = 1'b0;
        clear_req();
        // Inputs driven during reset must be ignored.
        exc = 1'b1;
        step();
        step();
        check_out("reset", 32'h0, 1'b0, 1'b0);

        // Free run after reset: 0, 4, 8, C with no flush.
        exc   = 1'b0;
        rst_n = 1'b1;
        check_out("free0", 32'h0, 1'b0, 1'b0);
        exp_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            check_out("free", exp_pc, 1'b0, 1'b0);
        end
        check("reach40", pc, 32'h40);

        // Backward branch: 0x3C + (-2 << 2) = 0x34.
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h3C; br_imm = 32'hFFFF_FFFE;
        step();
        check_out("br_back", 32'h34, 1'b1, 1'b0);
        clear_req();
        step();
        check_out("br_after", 32'h38, 1'b0, 1'b0);

        // Resolved but not taken is no request.
        br_valid = 1'b1; br_taken = 1'b0; br_pc = 32'h100; br_imm = 32'h10;
        step();
        check_out("br_nt", 32'h3C, 1'b0, 1'b0);
        clear_req();

        // Exception beats branch and jump in the same cycle.
        exc = 1'b1;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h200; br_imm = 32'h4;
        jmp_valid = 1'b1; jmp_pc = 32'h3000_0000; jmp_index = 26'h123;
        step();
        check_out("exc_pri", 32'h180, 1'b1, 1'b0);
        clear_req();
        step();
        check_out("exc_after", 32'h184, 1'b0, 1'b0);

        // Taken branch beats jump: 0x200 + 0x10 = 0x210.
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h200; br_imm = 32'h4;
        jmp_valid = 1'b1; jmp_pc = 32'h3000_0000; jmp_index = 26'h123;
        step();
        check_out("br_pri", 32'h210, 1'b1, 1'b0);

        // Jump alone on the very next cycle: back-to-back flush is allowed.
        clear_req();
        jmp_valid = 1'b1; jmp_pc = 32'h2000_0000; jmp_index = 26'h3FF_FFFF;
        step();
        check_out("jmp", 32'h2FFF_FFFC, 1'b1, 1'b0);
        clear_req();
        step();
        check_out("jmp_after", 32'h3000_0000, 1'b0, 1'b0);

        // Stall without a request holds pc and does not enter HOLD.
        stall = 1'b1;
        step();
        check_out("stall_idle", 32'h3000_0000, 1'b0, 1'b0);

        // Jump arrives while stalled and is held three cycles.
        held_pc = 32'h3000_0000;
        jmp_valid = 1'b1; jmp_pc = 32'h1000_0010; jmp_index = 26'h000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("hold_jmp", held_pc, 1'b0, 1'b1);
        end
        // Release: latched jump target wins over a branch offered this cycle.
        stall = 1'b0;
        clear_req();
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h700; br_imm = 32'h1;
        step();
        check_out("rel_jmp", 32'h1000_0400, 1'b1, 1'b0);
        clear_req();
        step();
        check_out("rel_after", 32'h1000_0404, 1'b0, 1'b0);

        // Branch latched in HOLD, then an exception pulse while stalled.
        stall = 1'b1;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h500; br_imm = 32'h8;
        step();
        check_out("hold_br", 32'h1000_0404, 1'b0, 1'b1);
        clear_req();
        exc = 1'b1;
        step();
        check_out("hold_exc", 32'h1000_0404, 1'b0, 1'b1);
        exc = 1'b0;
        // A new jump while in HOLD is ignored.
        jmp_valid = 1'b1; jmp_pc = 32'h4000_0000; jmp_index = 26'h10;
        step();
        check_out("hold_ign", 32'h1000_0404, 1'b0, 1'b1);
        clear_req();
        stall = 1'b0;
        step();
        check_out("rel_exc", 32'h180, 1'b1, 1'b0);

        // Exception on the release cycle overrides the latched target.
        stall = 1'b1;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h800; br_imm = 32'h4;
        step();
        check_out("hold_br2", 32'h180, 1'b0, 1'b1);
        clear_req();
        stall = 1'b0;
        exc   = 1'b1;
        step();
        check_out("rel_exc2", 32'h180, 1'b1, 1'b0);
        clear_req();

        // Wrap from 0xFFFF_FFFC to 0.
        jmp_valid = 1'b1; jmp_pc = 32'hF000_0000; jmp_index = 26'h3FF_FFFF;
        step();
        check_out("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        clear_req();
        step();
        check_out("wrap", 32'h0, 1'b0, 1'b0);

        // Branch target wraps past 2^32: 0xFFFF_FFF0 + 0x40 = 0x30.
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'hFFFF_FFF0; br_imm = 32'h10;
        step();
        check_out("br_wrap", 32'h30, 1'b1, 1'b0);
        clear_req();

        // Reset in HOLD drops the latched redirect.
        stall = 1'b1;
        jmp_valid = 1'b1; jmp_pc = 32'h5000_0000; jmp_index = 26'h40;
        step();
        check_out("pre_rst", 32'h30, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        check_out("rst_hold", 32'h0, 1'b0, 1'b0);
        clear_req();
        stall = 1'b0;
        rst_n = 1'b1;
        check_out("post_rst0", 32'h0, 1'b0, 1'b0);
        step();
        check_out("post_rst1", 32'h4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pc_ctrl.md
BRANCH_PC_CTRL -- requirements
Module: branch_pc_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port stall  input  1  pipeline stall; hold pc while high.
REQ-004 SHALL have port br_valid  input  1  branch resolved in EX this cycle.
REQ-005 SHALL have port br_taken  input  1  branch outcome; qualified by br_valid.
REQ-006 SHALL have port br_pc  input  32  PC+4 of the branch instruction.
REQ-007 SHALL have port br_imm  input  32  sign-extended word offset of the branch.
REQ-008 SHALL have port jmp_valid  input  1  J/JAL decoded in ID this cycle.
REQ-009 SHALL have port jmp_pc  input  32  PC+4 of the jump instruction.
REQ-010 SHALL have port jmp_index  input  26  jump instruction index field.
REQ-011 SHALL have port exc  input  1  exception request.
REQ-012 SHALL have port pc  output  32  current fetch address (registered).
REQ-013 SHALL have port flush  output  1  squash IF/ID contents (registered, one-cycle pulse).
REQ-014 SHALL have port pending  output  1  a redirect is latched awaiting stall release.

Function
REQ-015 Branch target SHALL be br_pc + (br_imm << 2), signed, modulo 2^32; carry discarded.
REQ-016 Jump target SHALL be {jmp_pc[31:28], jmp_index, 2'b00}.
REQ-017 Exception vector SHALL be the constant 0x0000_0180.
REQ-018 Redirect request priority SHALL be exc > (br_valid & br_taken) > jmp_valid; br_valid with br_taken=0 is no request.
REQ-019 FSM SHALL have two states: RUN and HOLD (pending = 1 only in HOLD).
REQ-020 RUN, stall=0, request present: pc <= selected target; flush <= 1 next cycle; stay RUN.
REQ-021 RUN, stall=0, no request: pc <= pc + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000); flush <= 0.
REQ-022 RUN, stall=1, request present: pc held; selected target and its kind latched in a pending register; go HOLD; flush <= 0.
REQ-023 RUN, stall=1, no request: pc held; flush <= 0.
REQ-024 HOLD, stall=1: pc held; a new exc SHALL overwrite the latched target with the vector; new branch/jump requests SHALL be ignored.
REQ-025 HOLD, stall=0: pc <= latched target, or vector if exc high that cycle; flush <= 1 next cycle; go RUN; branch/jump inputs that cycle ignored.
REQ-026 Latency: redirect visible on pc exactly one clock after acceptance; flush high during that same cycle only.
REQ-027 flush SHALL never be high for two consecutive cycles unless two redirects are accepted on consecutive unstalled cycles.
REQ-028 Target computation SHALL be combinational from inputs; only pc, flush, state and pending target are registers.

Reset
REQ-029 When rst_n=0 at a rising edge: pc <= 0x0000_0000, flush <= 0, state <= RUN, pending target <= 0; all inputs ignored.
REQ-030 Reset mid-HOLD SHALL discard the latched redirect; the first cycle after release fetches 0x0000_0000 then 0x0000_0004.

Verification
REQ-031 Reset then 3 free cycles -> pc = 0x0, 0x4, 0x8, 0xC; flush = 0 throughout.
REQ-032 pc=0x40, br_valid=1, br_taken=1, br_pc=0x3C, br_imm=0xFFFF_FFFE -> next pc = 0x34, flush = 1 for one cycle, then pc = 0x38.
REQ-033 Same cycle exc=1, branch taken, jmp_valid=1 -> next pc = 0x180 (exception wins), flush = 1.
REQ-034 stall=1 with jmp_valid=1, jmp_pc=0x1000_0010, jmp_index=0x0000_100 held 3 cycles -> pc held, pending=1; stall drops -> pc = 0x1000_0400, flush = 1, pending = 0.
REQ-035 In HOLD with branch latched, exc pulses while stalled -> after release pc = 0x180.
REQ-036 pc=0xFFFF_FFFC free-running -> next pc = 0x0000_0000; br_pc=0xFFFF_FFF0, br_imm=0x10 -> target 0x0000_0030.
